// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory-side handshake signals of the unified memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory environment view.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready_n;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready_n;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready_n;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, mem_rdata, mem_ready_n,
    output i_ready_n, i_rdata, d_ready_n, d_rdata,
    output mem_req, mem_write, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_size, d_addr, d_wdata, mem_rdata, mem_ready_n,
    input  i_ready_n, i_rdata, d_ready_n, d_rdata,
    input  mem_req, mem_write, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access: data has priority,
// fetch gets a forced grant after STARVE_LIMIT consecutive data grants while it waits.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        gap_q, gap_d;
  logic [3:0]  starveCnt_q, starveCnt_d;
  logic        holdWrite_q, holdWrite_d;
  logic [1:0]  holdSize_q, holdSize_d;
  logic [31:0] holdAddr_q, holdAddr_d;
  logic [31:0] holdWdata_q, holdWdata_d;

  logic forceI;
  logic iDone;
  logic dDone;

  assign forceI = (starveCnt_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gap_q       <= 1'b0;
      starveCnt_q <= 4'd0;
      holdWrite_q <= 1'b0;
      holdSize_q  <= 2'b00;
      holdAddr_q  <= 32'd0;
      holdWdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      starveCnt_q <= starveCnt_d;
      holdWrite_q <= holdWrite_d;
      holdSize_q  <= holdSize_d;
      holdAddr_q  <= holdAddr_d;
      holdWdata_q <= holdWdata_d;
    end
  end

  // In IDLE the winner drives the bus directly; gap_q forces one empty cycle after a held transfer.
  always_comb begin
    state_d       = state_q;
    gap_d         = 1'b0;
    holdWrite_d   = holdWrite_q;
    holdSize_d    = holdSize_q;
    holdAddr_d    = holdAddr_q;
    holdWdata_d   = holdWdata_q;
    bus.mem_req   = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_size  = 2'b00;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    iDone         = 1'b0;
    dDone         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!gap_q) begin
          if (bus.d_req && !forceI) begin
            bus.mem_req   = 1'b1;
            bus.mem_write = bus.d_write;
            bus.mem_size  = bus.d_size;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            if (!bus.mem_ready_n) begin
              dDone = 1'b1;
            end else begin
              state_d     = BUSY_D;
              holdWrite_d = bus.d_write;
              holdSize_d  = bus.d_size;
              holdAddr_d  = bus.d_addr;
              holdWdata_d = bus.d_wdata;
            end
          end else if (bus.i_req) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = bus.i_addr;
            if (!bus.mem_ready_n) begin
              iDone = 1'b1;
            end else begin
              state_d     = BUSY_I;
              holdWrite_d = 1'b0;
              holdSize_d  = 2'b00;
              holdAddr_d  = bus.i_addr;
              holdWdata_d = 32'd0;
            end
          end
        end
      end
      BUSY_I, BUSY_D: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = holdWrite_q;
        bus.mem_size  = holdSize_q;
        bus.mem_addr  = holdAddr_q;
        bus.mem_wdata = holdWdata_q;
        if (!bus.mem_ready_n) begin
          iDone   = (state_q == BUSY_I);
          dDone   = (state_q == BUSY_D);
          state_d = IDLE;
          gap_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      bus.mem_req   = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_size  = 2'b00;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;
      iDone         = 1'b0;
      dDone         = 1'b0;
    end
  end

  // Completion pulses and the starvation counter both follow from which owner finished this cycle.
  always_comb begin
    bus.i_ready_n = ~iDone;
    bus.d_ready_n = ~dDone;
    bus.i_rdata   = iDone ? bus.mem_rdata : 32'd0;
    bus.d_rdata   = dDone ? bus.mem_rdata : 32'd0;

    starveCnt_d = starveCnt_q;
    if (iDone) begin
      starveCnt_d = 4'd0;
    end else if (dDone && bus.i_req) begin
      starveCnt_d = (starveCnt_q >= LIMIT) ? LIMIT : starveCnt_q + 4'd1;
    end else if (state_q == IDLE && !bus.i_req) begin
      starveCnt_d = 4'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized protocol-legal
// traffic, all compared each cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: one outstanding held transaction, a one-cycle cooldown after it, and a streak count.
  bit          mBusy;
  bit          mBusyData;
  bit          mCooldown;
  int          mStreak;
  logic        mHeldWrite;
  logic [1:0]  mHeldSize;
  logic [31:0] mHeldAddr;
  logic [31:0] mHeldWdata;

  // Expected outputs for the current cycle, plus which requester the model granted.
  logic        expReq, expWrite;
  logic [1:0]  expSize;
  logic [31:0] expAddr, expWdata;
  logic        expIReady, expDReady;
  logic [31:0] expIRdata, expDRdata;
  bit          grantData, grantFetch;

  bit iPending;
  bit dPending;

  task automatic compareBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic compareWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic dWrite, input logic [1:0] dSize,
                               input logic [31:0] dAddr, input logic [31:0] dWdata,
                               input logic memReadyN, input logic [31:0] memRdata);
    bus.i_req       = iReq;
    bus.i_addr      = iAddr;
    bus.d_req       = dReq;
    bus.d_write     = dWrite;
    bus.d_size      = dSize;
    bus.d_addr      = dAddr;
    bus.d_wdata     = dWdata;
    bus.mem_ready_n = memReadyN;
    bus.mem_rdata   = memRdata;
  endtask

  // Work out what the arbiter should show this cycle, then compare every output against it.
  task automatic checkOutput(input string tag);
    bit completes;
    #1;
    expReq = 1'b0; expWrite = 1'b0; expSize = 2'b00; expAddr = 32'd0; expWdata = 32'd0;
    expIReady = 1'b1; expDReady = 1'b1; expIRdata = 32'd0; expDRdata = 32'd0;
    grantData = 1'b0; grantFetch = 1'b0;
    completes = 1'b0;
    if (!rst) begin
      if (mBusy) begin
        expReq = 1'b1; expWrite = mHeldWrite; expSize = mHeldSize;
        expAddr = mHeldAddr; expWdata = mHeldWdata;
        grantData = mBusyData; grantFetch = !mBusyData;
        completes = !bus.mem_ready_n;
      end else if (!mCooldown) begin
        if (bus.d_req && mStreak < STARVE_LIMIT) begin
          grantData = 1'b1;
          expReq = 1'b1; expWrite = bus.d_write; expSize = bus.d_size;
          expAddr = bus.d_addr; expWdata = bus.d_wdata;
        end else if (bus.i_req) begin
          grantFetch = 1'b1;
          expReq = 1'b1; expAddr = bus.i_addr;
        end
        completes = expReq && !bus.mem_ready_n;
      end
      if (completes && grantData) begin
        expDReady = 1'b0; expDRdata = bus.mem_rdata;
      end
      if (completes && grantFetch) begin
        expIReady = 1'b0; expIRdata = bus.mem_rdata;
      end
    end
    compareBit({tag, ".mem_req"}, bus.mem_req, expReq);
    compareBit({tag, ".mem_write"}, bus.mem_write, expWrite);
    compareWord({tag, ".mem_size"}, {30'd0, bus.mem_size}, {30'd0, expSize});
    compareWord({tag, ".mem_addr"}, bus.mem_addr, expAddr);
    compareWord({tag, ".mem_wdata"}, bus.mem_wdata, expWdata);
    compareBit({tag, ".i_ready_n"}, bus.i_ready_n, expIReady);
    compareWord({tag, ".i_rdata"}, bus.i_rdata, expIRdata);
    compareBit({tag, ".d_ready_n"}, bus.d_ready_n, expDReady);
    compareWord({tag, ".d_rdata"}, bus.d_rdata, expDRdata);
  endtask

  // Advance one clock and move the model forward using this cycle's inputs and expectations.
  task automatic advanceClock();
    bit nextCooldown;
    @(posedge clk);
    if (rst) begin
      mBusy = 1'b0; mBusyData = 1'b0; mCooldown = 1'b0; mStreak = 0;
      mHeldWrite = 1'b0; mHeldSize = 2'b00; mHeldAddr = 32'd0; mHeldWdata = 32'd0;
    end else begin
      nextCooldown = 1'b0;
      if (!expIReady) mStreak = 0;
      else if (!expDReady && bus.i_req) mStreak = (mStreak + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mStreak + 1;
      else if (!mBusy && !bus.i_req) mStreak = 0;
      if (mBusy) begin
        if (!bus.mem_ready_n) begin
          mBusy = 1'b0;
          nextCooldown = 1'b1;
        end
      end else if (expReq && bus.mem_ready_n) begin
        mBusy = 1'b1; mBusyData = grantData;
        mHeldWrite = expWrite; mHeldSize = expSize; mHeldAddr = expAddr; mHeldWdata = expWdata;
      end
      mCooldown = nextCooldown;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mBusy = 1'b0; mBusyData = 1'b0; mCooldown = 1'b0; mStreak = 0;
    mHeldWrite = 1'b0; mHeldSize = 2'b00; mHeldAddr = 32'd0; mHeldWdata = 32'd0;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 2'b01, 32'h80, 32'hFF, 1'b0, 32'h1234);
    @(negedge clk);

    // Reset holds the bus quiet even with both requesters and the memory active.
    checkOutput("reset");
    compareBit("reset.mem_req_const", bus.mem_req, 1'b0);
    compareBit("reset.d_ready_const", bus.d_ready_n, 1'b1);
    advanceClock();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0);
    checkOutput("reset2");
    advanceClock();
    rst = 1'b0;

    // Single zero-wait fetch completes in the cycle it is granted.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'h13);
    checkOutput("fetch0");
    compareWord("fetch0.addr_const", bus.mem_addr, 32'h100);
    compareBit("fetch0.iready_const", bus.i_ready_n, 1'b0);
    compareWord("fetch0.irdata_const", bus.i_rdata, 32'h13);
    advanceClock();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0);
    checkOutput("idle");
    advanceClock();

    // Both request: data owns the bus for three cycles, ignores an address change, then a gap.
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 2'b10, 32'h2003, 32'hAB, 1'b1, 32'd0);
    checkOutput("both.c1");
    compareWord("both.c1.addr_const", bus.mem_addr, 32'h2003);
    advanceClock();
    bus.d_addr = 32'h9999;
    checkOutput("both.c2");
    compareWord("both.c2.hold_const", bus.mem_addr, 32'h2003);
    advanceClock();
    bus.d_addr = 32'h2003;
    bus.mem_ready_n = 1'b0;
    bus.mem_rdata = 32'h55;
    checkOutput("both.c3");
    compareBit("both.c3.dready_const", bus.d_ready_n, 1'b0);
    advanceClock();
    bus.d_req = 1'b0;
    checkOutput("both.c4");
    compareBit("both.c4.gap_const", bus.mem_req, 1'b0);
    advanceClock();
    bus.mem_rdata = 32'h77;
    checkOutput("both.c5");
    compareWord("both.c5.iaddr_const", bus.mem_addr, 32'h200);
    compareBit("both.c5.iready_const", bus.i_ready_n, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0);
    checkOutput("both.idle");
    advanceClock();

    // Starvation guard: four data completions, one forced fetch, then data again.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 2'b00, 32'h400 + 32'(k), 32'd0, 1'b0, 32'h1000 + 32'(k));
      checkOutput("starve");
      compareBit("starve.iready_const", bus.i_ready_n, (k == 4) ? 1'b0 : 1'b1);
      advanceClock();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0);
    checkOutput("starve.idle");
    advanceClock();

    // Reset during a held fetch abandons it; a fresh data request is granted right after.
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0);
    checkOutput("rstmid.c1");
    advanceClock();
    rst = 1'b1;
    checkOutput("rstmid.c2");
    compareBit("rstmid.c2.req_const", bus.mem_req, 1'b0);
    compareBit("rstmid.c2.iready_const", bus.i_ready_n, 1'b1);
    advanceClock();
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 2'b01, 32'h600, 32'd0, 1'b0, 32'hCAFE);
    checkOutput("rstmid.c3");
    compareBit("rstmid.c3.dready_const", bus.d_ready_n, 1'b0);
    advanceClock();

    // Randomized protocol-legal traffic: each requester holds its request until it completes.
    iPending = 1'b0;
    dPending = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (!iPending) begin
        bus.i_req  = 1'($urandom_range(0, 1));
        bus.i_addr = 32'($urandom);
      end
      if (!dPending) begin
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_write = 1'($urandom_range(0, 1));
        bus.d_size  = 2'($urandom_range(0, 2));
        bus.d_addr  = 32'($urandom);
        bus.d_wdata = 32'($urandom);
      end
      bus.mem_ready_n = ($urandom_range(0, 4) < 2);
      bus.mem_rdata   = 32'($urandom);
      checkOutput("rand");
      iPending = !rst && bus.i_req && expIReady;
      dPending = !rst && bus.d_req && expDReady;
      advanceClock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
